// File: rtl/keystone_pkg.sv
// Shared constants, state encoding and colour unpacking for the pixel stream ingest block.
package keystone_pkg;

    localparam int DEFAULT_WIDTH  = 1920;
    localparam int DEFAULT_HEIGHT = 1080;

    // Each 32-bit pixel word carries 10-bit channels; only the top 8 bits of each are kept.
    localparam int CHAN_W = 8;
    localparam int G_LSB  = 2;
    localparam int B_LSB  = 12;
    localparam int R_LSB  = 22;

    typedef enum logic [1:0] {
        ST_SYNC  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_EMIT0 = 2'd2,
        ST_EMIT1 = 2'd3
    } state_e;

    localparam int STAT_SOF_EARLY  = 0;
    localparam int STAT_SHORT_LINE = 1;
    localparam int STAT_LONG_LINE  = 2;
    localparam int STAT_IN_FRAME   = 3;
    localparam int STAT_FCNT_LSB   = 4;

    typedef struct packed {
        logic [CHAN_W-1:0] r;
        logic [CHAN_W-1:0] g;
        logic [CHAN_W-1:0] b;
    } rgb_t;

    function automatic rgb_t rgb_extract(input logic [31:0] word);
        rgb_t c;
        c.r = word[R_LSB +: CHAN_W];
        c.g = word[G_LSB +: CHAN_W];
        c.b = word[B_LSB +: CHAN_W];
        return c;
    endfunction

endpackage

// File: rtl/pixel_stream_ingest.sv
// Unpacks a two-pixel-per-beat video stream into single-pixel coordinate writes,
// tracking line/frame geometry and flagging framing errors in sticky status bits.
module pixel_stream_ingest
    import keystone_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int HEIGHT = DEFAULT_HEIGHT
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [63:0]        s_tdata,
    input  logic               s_tvalid,
    input  logic               s_tuser,
    input  logic               s_tlast,
    output logic               s_tready,
    output logic               wr_valid,
    input  logic               wr_ready,
    output logic signed [31:0] wr_x,
    output logic signed [31:0] wr_y,
    output logic [7:0]         wr_r,
    output logic [7:0]         wr_g,
    output logic [7:0]         wr_b,
    input  logic               clear_errors,
    output logic               frame_done,
    output logic [7:0]         status,
    output state_e             dbg_state_o
);

    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // valid never depends on ready, and wr_* hold while wr_valid && !wr_ready.

    state_e             state_q;
    logic [63:0]        data_q;
    logic               last_q;
    logic signed [31:0] x_q;
    logic signed [31:0] y_q;
    logic               frame_done_q;
    logic [2:0]         err_q;
    logic [3:0]         fcnt_q;

    logic signed [31:0] x_plus2_d;
    logic signed [31:0] x_adv_d;
    logic signed [31:0] y_adv_d;
    logic               line_full;
    logic               row_wrap;
    logic               frame_end;
    logic               beat_acc;
    logic               emit;
    logic [31:0]        pix_word;
    rgb_t               pix;

    assign x_plus2_d = x_q + 32'sd2;
    assign line_full = (x_plus2_d == WIDTH);
    assign row_wrap  = last_q || line_full;
    assign frame_end = row_wrap && (y_q == HEIGHT - 1);
    assign x_adv_d   = row_wrap ? 32'sd0 : x_plus2_d;
    assign y_adv_d   = row_wrap ? (y_q + 32'sd1) : y_q;

    assign emit     = (state_q == ST_EMIT0) || (state_q == ST_EMIT1);
    assign s_tready = !reset && ((state_q == ST_SYNC) || (state_q == ST_LOAD) ||
                                 ((state_q == ST_EMIT1) && wr_ready));
    assign beat_acc = s_tvalid && s_tready;

    assign pix_word = (state_q == ST_EMIT1) ? data_q[63:32] : data_q[31:0];
    assign pix      = rgb_extract(pix_word);

    assign wr_valid = !reset && emit;
    assign wr_x     = (state_q == ST_EMIT1) ? (x_q + 32'sd1) : x_q;
    assign wr_y     = y_q;
    assign wr_r     = pix.r;
    assign wr_g     = pix.g;
    assign wr_b     = pix.b;

    assign frame_done  = frame_done_q && !reset;
    assign status      = reset ? 8'h00 : {fcnt_q, (state_q != ST_SYNC), err_q};
    assign dbg_state_o = state_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_SYNC;
            data_q       <= '0;
            last_q       <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
            frame_done_q <= 1'b0;
            err_q        <= '0;
            fcnt_q       <= '0;
        end else begin
            frame_done_q <= 1'b0;
            // Error sets below are later assignments, so they win over a same-cycle clear.
            if (clear_errors) begin
                err_q <= '0;
            end
            case (state_q)
                ST_SYNC: begin
                    if (beat_acc && s_tuser) begin
                        data_q  <= s_tdata;
                        last_q  <= s_tlast;
                        x_q     <= '0;
                        y_q     <= '0;
                        state_q <= ST_EMIT0;
                    end
                end
                ST_LOAD: begin
                    if (beat_acc) begin
                        data_q  <= s_tdata;
                        last_q  <= s_tlast;
                        state_q <= ST_EMIT0;
                        if (s_tuser) begin
                            err_q[STAT_SOF_EARLY] <= 1'b1;
                            x_q <= '0;
                            y_q <= '0;
                        end
                    end
                end
                ST_EMIT0: begin
                    if (wr_ready) begin
                        state_q <= ST_EMIT1;
                    end
                end
                ST_EMIT1: begin
                    if (wr_ready) begin
                        if (last_q && (x_plus2_d < WIDTH)) begin
                            err_q[STAT_SHORT_LINE] <= 1'b1;
                        end
                        if (line_full && !last_q) begin
                            err_q[STAT_LONG_LINE] <= 1'b1;
                        end
                        // Frame end always resyncs; any beat offered alongside it is dropped.
                        if (frame_end) begin
                            frame_done_q <= 1'b1;
                            fcnt_q       <= fcnt_q + 4'd1;
                            x_q          <= '0;
                            y_q          <= '0;
                            state_q      <= ST_SYNC;
                        end else if (beat_acc && s_tuser) begin
                            err_q[STAT_SOF_EARLY] <= 1'b1;
                            data_q  <= s_tdata;
                            last_q  <= s_tlast;
                            x_q     <= '0;
                            y_q     <= '0;
                            state_q <= ST_EMIT0;
                        end else begin
                            x_q <= x_adv_d;
                            y_q <= y_adv_d;
                            if (beat_acc) begin
                                data_q  <= s_tdata;
                                last_q  <= s_tlast;
                                state_q <= ST_EMIT0;
                            end else begin
                                state_q <= ST_LOAD;
                            end
                        end
                    end
                end
                default: state_q <= ST_SYNC;
            endcase
        end
    end

endmodule

// File: doc/pixel_stream_ingest.md
PIXEL_STREAM_INGEST -- requirements
Module: pixel_stream_ingest

Interface
REQ-001 Parameters SHALL be: WIDTH, 1920, active pixels per line (even, >=4); HEIGHT, 1080, lines per frame (>=2).
REQ-002 clock  in  1  single clock; all logic on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 s_tdata  in  64  two pixels per beat; pixel0 = [31:0], pixel1 = [63:32].
REQ-005 s_tvalid  in  1  input beat valid.
REQ-006 s_tuser  in  1  start of frame, marks the first beat of a frame.
REQ-007 s_tlast  in  1  end of line, marks the last beat of a line.
REQ-008 s_tready  out  1  beat accepted when s_tvalid && s_tready.
REQ-009 wr_valid  out  1  pixel write request.
REQ-010 wr_ready  in  1  write sink accepts the pixel when wr_valid && wr_ready.
REQ-011 wr_x, wr_y  out  32 each  signed int pixel coordinates.
REQ-012 wr_r, wr_g, wr_b  out  8 each  pixel colour.
REQ-013 clear_errors  in  1  single-cycle pulse; clears the sticky error bits.
REQ-014 frame_done  out  1  one-cycle pulse after the last pixel of a frame is written.
REQ-015 status  out  8  [0] err_sof_early, [1] err_short_line, [2] err_long_line, [3] in_frame, [7:4] frame count mod 16.

Function
REQ-016 Colour extraction per 32-bit word SHALL be: g=[9:2], b=[19:12], r=[29:22]; all other bits are ignored.
REQ-017 The FSM SHALL have the states SYNC, LOAD, EMIT0 and EMIT1, all registered.
REQ-018 SYNC: s_tready=1, wr_valid=0; beats with s_tuser=0 are discarded; an accepted beat with s_tuser=1 is latched, sets x=0, y=0, and goes to EMIT0.
REQ-019 LOAD: s_tready=1, wr_valid=0; an accepted beat is latched and goes to EMIT0.
REQ-020 EMIT0: wr_valid=1 with pixel0 at (x,y); on wr_ready, go to EMIT1; s_tready=0.
REQ-021 EMIT1: wr_valid=1 with pixel1 at (x+1,y); s_tready=wr_ready.
REQ-022 EMIT1 handshake SHALL advance the coordinates, then latch a new beat (go to EMIT0) if s_tvalid, otherwise go to LOAD.
REQ-023 Coordinate advance SHALL be: if the latched s_tlast=1 or x+2==WIDTH, then x=0 and y=y+1; otherwise x=x+2.
REQ-024 If the latched s_tlast=1 and x+2<WIDTH, err_short_line SHALL be set.
REQ-025 If x+2==WIDTH and the latched s_tlast=0, err_long_line SHALL be set.
REQ-026 When the advance wraps a row with y==HEIGHT-1: frame_done SHALL pulse on the next cycle, the frame count SHALL increment, and the FSM SHALL go to SYNC, not EMIT0, even if s_tvalid.
REQ-027 An accepted beat with s_tuser=1 in LOAD or EMIT1 SHALL set err_sof_early and restart at x=0, y=0 with that beat, without asserting frame_done.
REQ-028 Latency: a beat accepted in cycle N SHALL present pixel0 in N+1 and pixel1 in N+2 when wr_ready=1.
REQ-029 Sustained throughput SHALL be one pixel per cycle.
REQ-030 wr_* SHALL hold stable while wr_valid && !wr_ready.
REQ-031 Error bits SHALL be sticky; clear_errors clears them, and an error set in the same cycle as clear_errors wins.
REQ-032 in_frame SHALL equal (state != SYNC).
REQ-033 The frame counter SHALL wrap from 15 to 0.

Reset
REQ-034 While reset=1: s_tready=0, wr_valid=0, frame_done=0.
REQ-035 While reset=1: state=SYNC, x=y=0, status=0, and the latched beat is cleared.
REQ-036 Reset mid-frame SHALL abandon the current beat; the first post-reset pixel written is the first pixel of the next s_tuser beat.

Structure
REQ-037 keystone_pkg SHALL hold: the default WIDTH/HEIGHT, colour bit-field constants, the state enum, the status bit indices, and an rgb-extract function.
REQ-038 No sub-module is required; the block is a single module of one FSM plus a coordinate datapath.

Verification (WIDTH=8, HEIGHT=2)
REQ-039 Clean frame: 8 beats, tuser on beat 0, tlast on beats 3 and 7, wr_ready=1 -> 16 writes in order (0,0)..(7,1), status=0x10, frame_done one cycle after write (7,1).
REQ-040 Backpressure: wr_ready toggling 1,0 -> no pixel lost or duplicated, wr_* stable while stalled, s_tready low during stalls.
REQ-041 Short line: tlast on beat 1 of line 0 -> writes (0,0)..(3,0), next beat written at (0,1), status[1]=1.
REQ-042 Long line: no tlast on beat 3 -> row wraps to (0,1), status[2]=1.
REQ-043 Early SOF: tuser on beat 2 -> status[0]=1, that beat written at (0,0),(1,0), no frame_done.
REQ-044 Pre-sync garbage and reset: 3 beats with tuser=0 then a tuser beat -> first write is from the tuser beat; reset asserted mid-line -> outputs zero, resync on the next tuser.
